// File: rtl/code_entry_pkg.sv
// Shared types and width helpers for the code-entry game controller.
//   state_t  : controller states (ENTRY, CHECK, PASS, LOSE)
//   count_w  : bits needed to hold a count of 0..max_val
//   timer_w  : bits needed for a cycle counter running 0..cycles-1
package code_entry_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CHECK = 2'd1,
        PASS  = 2'd2,
        LOSE  = 2'd3
    } state_t;

    function automatic int count_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int timer_w(input int cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Button front end: two-flop synchronizer followed by a rising-edge detector.
// A held button yields a single one-cycle pulse.
//   clk   : system clock
//   reset : synchronous, active-high reset (clears all flops)
//   raw   : asynchronous button level, active-high
//   pulse : one-cycle strobe, high in the second cycle after raw is first sampled high
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // High while the synchronized level is new; consumed on the following edge
    assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/code_entry_game.sv
// Code-entry game controller feeding the six-digit result display.
// The player enters CODE_LEN digits, one per button press; the entry is
// compared against SECRET. Wrong entries or an idle timeout mid-entry cost a
// try; running out of tries raises lose, a correct entry raises pass. Both
// flags are sticky until reset or clear.
//   clk         : system clock
//   reset       : synchronous, active-high reset, overrides everything
//   clear       : synchronous restart of the game
//   enter_raw   : asynchronous button level, active-high
//   digit       : switch value captured on each press
//   lose        : registered, high in LOSE
//   pass        : registered, high in PASS
//   digit_count : digits captured in the current attempt
//   tries_left  : attempts remaining
module code_entry_game
    import code_entry_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] SECRET = 16'h1234
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              enter_raw,
    input  logic [DIGIT_W-1:0]                digit,
    output logic                              lose,
    output logic                              pass,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left
);

    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = timer_w(TIMEOUT_CYCLES);
    localparam int BUF_W = CODE_LEN * DIGIT_W;

    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             state_r,  state_n;
    logic [CNT_W-1:0]   count_r,  count_n;
    logic [TRY_W-1:0]   tries_r,  tries_n;
    logic [BUF_W-1:0]   buffer_r, buffer_n;
    logic [TMR_W-1:0]   timer_r,  timer_n;
    logic               tfail_r,  tfail_n;
    logic               lose_r,   lose_n;
    logic               pass_r,   pass_n;
    logic               press_s;

    key_sync_edge u_enter (
        .clk   (clk),
        .reset (reset),
        .raw   (enter_raw),
        .pulse (press_s)
    );

    // Next-state, datapath and output-flag decode
    always_comb begin
        state_n  = state_r;
        count_n  = count_r;
        tries_n  = tries_r;
        buffer_n = buffer_r;
        timer_n  = timer_r;
        tfail_n  = tfail_r;

        if (clear) begin
            // Restart wins over a same-cycle press; that press is dropped
            state_n  = ENTRY;
            count_n  = {CNT_W{1'b0}};
            tries_n  = TRIES_INIT;
            buffer_n = {BUF_W{1'b0}};
            timer_n  = {TMR_W{1'b0}};
            tfail_n  = 1'b0;
        end else begin
            case (state_r)
                ENTRY: begin
                    if (press_s) begin
                        // Slot 0 (first digit entered) is the most significant
                        for (int i = 0; i < CODE_LEN; i++) begin
                            buffer_n[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] =
                                (count_r == CNT_W'(i)) ? digit
                                                       : buffer_r[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
                        end
                        count_n = count_r + CNT_W'(1);
                        timer_n = {TMR_W{1'b0}};
                        if (count_r == LAST_SLOT) begin
                            state_n = CHECK;
                        end else begin
                            state_n = ENTRY;
                        end
                    end else if (count_r != {CNT_W{1'b0}}) begin
                        // Idle mid-entry: fail the attempt once the budget is spent
                        if (timer_r == TMR_LAST) begin
                            tfail_n = 1'b1;
                            state_n = CHECK;
                        end else begin
                            timer_n = timer_r + TMR_W'(1);
                        end
                    end else begin
                        // Nothing entered yet: wait indefinitely
                        timer_n = {TMR_W{1'b0}};
                    end
                end
                CHECK: begin
                    if (!tfail_r && (buffer_r == SECRET)) begin
                        state_n = PASS;
                    end else begin
                        tries_n = tries_r - TRY_W'(1);
                        if (tries_r == TRY_W'(1)) begin
                            state_n = LOSE;
                        end else begin
                            state_n  = ENTRY;
                            count_n  = {CNT_W{1'b0}};
                            buffer_n = {BUF_W{1'b0}};
                            timer_n  = {TMR_W{1'b0}};
                            tfail_n  = 1'b0;
                        end
                    end
                end
                PASS: begin
                    state_n = PASS;
                end
                LOSE: begin
                    state_n = LOSE;
                end
                default: begin
                    state_n = ENTRY;
                end
            endcase
        end

        // Flags are registered from the next state so they track the state register
        lose_n = (state_n == LOSE);
        pass_n = (state_n == PASS);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ENTRY;
            count_r  <= {CNT_W{1'b0}};
            tries_r  <= TRIES_INIT;
            buffer_r <= {BUF_W{1'b0}};
            timer_r  <= {TMR_W{1'b0}};
            tfail_r  <= 1'b0;
            lose_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            count_r  <= count_n;
            tries_r  <= tries_n;
            buffer_r <= buffer_n;
            timer_r  <= timer_n;
            tfail_r  <= tfail_n;
            lose_r   <= lose_n;
            pass_r   <= pass_n;
        end
    end

    assign lose        = lose_r;
    assign pass        = pass_r;
    assign digit_count = count_r;
    assign tries_left  = tries_r;

endmodule

// File: tb/tb_code_entry_game.sv
// Self-checking bench for code_entry_game (TIMEOUT_CYCLES overridden to 20).
// Expected {lose, pass, digit_count, tries_left} vectors are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_code_entry_game;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       enter_raw;
    logic [3:0] digit;
    logic       lose;
    logic       pass;
    logic [2:0] digit_count;
    logic [1:0] tries_left;
    logic [6:0] obs_s;

    string      tag_q[$];
    logic [6:0] val_q[$];
    string      exp_tag;
    logic [6:0] exp_v;
    int         n_checks;
    int         n_fail;

    code_entry_game #(
        .CODE_LEN       (4),
        .DIGIT_W        (4),
        .MAX_TRIES      (3),
        .TIMEOUT_CYCLES (20),
        .SECRET         (16'h1234)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .enter_raw   (enter_raw),
        .digit       (digit),
        .lose        (lose),
        .pass        (pass),
        .digit_count (digit_count),
        .tries_left  (tries_left)
    );

    assign obs_s = {lose, pass, digit_count, tries_left};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input logic l, input logic p,
                                      input logic [2:0] c, input logic [1:0] t);
        return {l, p, c, t};
    endfunction

    task automatic exp_push(input string tag, input logic [6:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    // Press and release; capture lands on the 3rd edge, returns 8 negedges later
    task automatic press(input logic [3:0] d);
        digit     = d;
        enter_raw = 1'b1;
        repeat (4) @(negedge clk);
        enter_raw = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_push("reset_state", pk(1'b0, 1'b0, 3'd0, 2'd3));
        @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
    endtask

    task automatic test_pass;
        for (int i = 1; i <= 3; i++) begin
            exp_push("pass_entry_count", pk(1'b0, 1'b0, 3'(i), 2'd3));
            press(4'(i));
            begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        end
        digit     = 4'h4;
        enter_raw = 1'b1;
        exp_push("pass_check_cycle", pk(1'b0, 1'b0, 3'd4, 2'd3));
        exp_push("pass_flag", pk(1'b0, 1'b1, 3'd4, 2'd3));
        repeat (3) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        enter_raw = 1'b0;
        repeat (4) @(negedge clk);
        exp_push("pass_sticky", pk(1'b0, 1'b1, 3'd4, 2'd3));
        repeat (7) press(4'(($urandom % 9) + 1));
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
    endtask

    task automatic test_reset_in_pass;
        reset = 1'b1;
        exp_push("reset_in_pass", pk(1'b0, 1'b0, 3'd0, 2'd3));
        @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrong_codes;
        for (int a = 0; a < 3; a++) begin
            if (a == 2) exp_push("wrong_to_lose", pk(1'b1, 1'b0, 3'd4, 2'd0));
            else        exp_push("wrong_try_used", pk(1'b0, 1'b0, 3'd0, 2'(2 - a)));
            press(4'h1);
            press(4'h2);
            press(4'h3);
            press(4'h5);
            begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        end
        exp_push("lose_ignores_press", pk(1'b1, 1'b0, 3'd4, 2'd0));
        press(4'h1);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
    endtask

    // Clear lands on the edge that would capture the press (once in LOSE, once in ENTRY)
    task automatic test_clear_vs_press;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                exp_push("entry_one_digit", pk(1'b0, 1'b0, 3'd1, 2'd3));
                press(4'h1);
                begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
            end
            digit     = 4'h2;
            enter_raw = 1'b1;
            repeat (2) @(negedge clk);
            clear = 1'b1;
            exp_push("clear_beats_press", pk(1'b0, 1'b0, 3'd0, 2'd3));
            @(negedge clk);
            clear = 1'b0;
            begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
            repeat (3) @(negedge clk);
            enter_raw = 1'b0;
            exp_push("press_dropped", pk(1'b0, 1'b0, 3'd0, 2'd3));
            repeat (4) @(negedge clk);
            begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        end
    endtask

    task automatic test_timeout;
        press(4'h1);
        press(4'h2);
        // 5 edges since the last capture so far
        exp_push("timeout_not_yet", pk(1'b0, 1'b0, 3'd2, 2'd3));
        repeat (10) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        exp_push("timeout_fail", pk(1'b0, 1'b0, 3'd0, 2'd2));
        repeat (10) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        exp_push("idle_no_timeout", pk(1'b0, 1'b0, 3'd0, 2'd2));
        repeat (100) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
    endtask

    task automatic test_held_button;
        digit     = 4'h7;
        enter_raw = 1'b1;
        exp_push("held_edge2", pk(1'b0, 1'b0, 3'd0, 2'd2));
        exp_push("held_edge3", pk(1'b0, 1'b0, 3'd1, 2'd2));
        exp_push("held_single", pk(1'b0, 1'b0, 3'd1, 2'd2));
        exp_push("held_then_timeout", pk(1'b0, 1'b0, 3'd0, 2'd1));
        repeat (2) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        repeat (15) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        // Still held: the idle timer expires 20 edges after the capture
        repeat (12) @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        enter_raw = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_entry;
        press(4'h1);
        exp_push("mid_entry_count", pk(1'b0, 1'b0, 3'd2, 2'd1));
        press(4'h2);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        reset = 1'b1;
        exp_push("reset_mid_entry", pk(1'b0, 1'b0, 3'd0, 2'd3));
        @(negedge clk);
        begin exp_v = val_q.pop_front(); exp_tag = tag_q.pop_front(); n_checks++; if (obs_s !== exp_v) begin n_fail++; $display("FAIL %s: got %b expected %b", exp_tag, obs_s, exp_v); end end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Guards against a hung run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        clear     = 1'b0;
        enter_raw = 1'b0;
        digit     = 4'h0;
        @(negedge clk);
        test_reset;
        test_pass;
        test_reset_in_pass;
        test_wrong_codes;
        test_clear_vs_press;
        test_timeout;
        test_held_button;
        test_reset_mid_entry;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
